// File: rtl/gain_hist_pkg.sv
// Shared definitions for the gain-history updater: FSM state encodings,
// default constants and the 16->32 sign-extension helper.
package gain_hist_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_ACC_RD  = 4'd1,
        ST_ACC_ADD = 4'd2,
        ST_AVG     = 4'd3,
        ST_OFFS    = 4'd4,
        ST_CLAMP   = 4'd5,
        ST_CEIL    = 4'd6,
        ST_SH_RD   = 4'd7,
        ST_SH_WR   = 4'd8,
        ST_WR0     = 4'd9,
        ST_FIN     = 4'd10
    } gh_state_e;

    localparam logic [15:0] OFFSET_DEF = 16'd4096;
    localparam logic [15:0] FLOOR_DEF  = 16'hC800;   // -14336
    localparam logic [15:0] CEIL_DEF   = 16'h0000;
    // Stand-in for PAST_QUA_EN; integrations override BASE_ADDR with the real value.
    localparam logic [11:0] BASE_ADDR_DEF = 12'h040;

    function automatic logic [31:0] sext16to32(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/gain_hist_update_if.sv
// Handshake, shared-operator and scratch-memory signals of gain_hist_update.
// slave: the updater itself; master: the surrounding decoder / operator pool.
interface gain_hist_update_if;

    logic        start;
    logic        mode;
    logic [15:0] qua_en_in;
    logic        done;
    logic [15:0] avg_out;
    logic [15:0] sub_a;
    logic [15:0] sub_b;
    logic [15:0] sub_in;
    logic [31:0] L_add_a;
    logic [31:0] L_add_b;
    logic [31:0] L_add_in;
    logic [31:0] L_shr_a;
    logic [15:0] L_shr_b;
    logic [31:0] L_shr_in;
    logic [11:0] scratch_mem_read_addr;
    logic [11:0] scratch_mem_write_addr;
    logic [31:0] scratch_mem_out;
    logic        scratch_mem_write_en;
    logic [31:0] scratch_mem_in;

    modport slave (
        input  start, mode, qua_en_in, sub_in, L_add_in, L_shr_in, scratch_mem_in,
        output done, avg_out, sub_a, sub_b, L_add_a, L_add_b, L_shr_a, L_shr_b,
               scratch_mem_read_addr, scratch_mem_write_addr, scratch_mem_out,
               scratch_mem_write_en
    );

    modport master (
        output start, mode, qua_en_in, sub_in, L_add_in, L_shr_in, scratch_mem_in,
        input  done, avg_out, sub_a, sub_b, L_add_a, L_add_b, L_shr_a, L_shr_b,
               scratch_mem_read_addr, scratch_mem_write_addr, scratch_mem_out,
               scratch_mem_write_en
    );

endinterface

// File: rtl/gain_hist_update.sv
// Predictor-energy history updater for the decoder gain path.
// Erasure: new = clamp(avg(history) - OFFSET); update: new = qua_en_in.
// The history is then shifted by one slot and new is written to slot 0.
// Optional macro GAIN_HIST_CEIL_EN adds an upper clamp to CEIL in erasure mode.
//
// state   | meaning
// IDLE    | wait for start, latch mode / qua_en
// ACC_RD  | present read address of slot i
// ACC_ADD | accumulate slot i into L_tmp, last slot goes on to AVG
// AVG     | a = L_shr(L_tmp, LOG2_DEPTH)
// OFFS    | a = a - OFFSET
// CLAMP   | lower clamp to FLOOR, arm shift counter
// CEIL    | upper clamp to CEIL (GAIN_HIST_CEIL_EN only)
// SH_RD   | read slot i-1, or finish shifting when i==0
// SH_WR   | write read word into slot i
// WR0     | write new value into slot 0, update avg_out
// FIN     | done pulse
module gain_hist_update
    import gain_hist_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter int          LOG2_DEPTH = 2,
    parameter logic [11:0] BASE_ADDR  = BASE_ADDR_DEF,
    parameter logic [15:0] OFFSET     = OFFSET_DEF,
    parameter logic [15:0] FLOOR      = FLOOR_DEF,
    parameter logic [15:0] CEIL       = CEIL_DEF
) (
    input  logic              clk,
    input  logic              reset,
    gain_hist_update_if.slave bus
);

    gh_state_e   state, state_nx;
    logic [4:0]  i;
    logic [31:0] l_tmp;
    logic [15:0] a;
    logic        mode_q;
    logic [15:0] qua_en_q;
    logic [15:0] new_val;
    logic        last_slot;
    logic        unused_bits;

    assign new_val   = mode_q ? qua_en_q : a;
    assign last_slot = (i == 5'(DEPTH - 1));

`ifdef GAIN_HIST_CEIL_EN
    assign unused_bits = ^bus.L_shr_in[31:16];
`else
    assign unused_bits = ^{bus.L_shr_in[31:16], CEIL};
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next-state decode and operator / memory strobes.
    always_comb begin
        state_nx                   = state;
        bus.sub_a                  = '0;
        bus.sub_b                  = '0;
        bus.L_add_a                = '0;
        bus.L_add_b                = '0;
        bus.L_shr_a                = '0;
        bus.L_shr_b                = '0;
        bus.scratch_mem_read_addr  = '0;
        bus.scratch_mem_write_addr = '0;
        bus.scratch_mem_out        = '0;
        bus.scratch_mem_write_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) state_nx = bus.mode ? ST_SH_RD : ST_ACC_RD;
            end
            ST_ACC_RD: begin
                bus.scratch_mem_read_addr = BASE_ADDR + 12'(i);
                state_nx = ST_ACC_ADD;
            end
            ST_ACC_ADD: begin
                bus.L_add_a = l_tmp;
                bus.L_add_b = sext16to32(bus.scratch_mem_in[15:0]);
                state_nx = last_slot ? ST_AVG : ST_ACC_RD;
            end
            ST_AVG: begin
                bus.L_shr_a = l_tmp;
                bus.L_shr_b = 16'(LOG2_DEPTH);
                state_nx = ST_OFFS;
            end
            ST_OFFS: begin
                bus.sub_a = a;
                bus.sub_b = OFFSET;
                state_nx = ST_CLAMP;
            end
            ST_CLAMP: begin
                bus.sub_a = a;
                bus.sub_b = FLOOR;
`ifdef GAIN_HIST_CEIL_EN
                state_nx = ST_CEIL;
`else
                state_nx = ST_SH_RD;
`endif
            end
`ifdef GAIN_HIST_CEIL_EN
            ST_CEIL: begin
                bus.sub_a = a;
                bus.sub_b = CEIL;
                state_nx = ST_SH_RD;
            end
`endif
            ST_SH_RD: begin
                if (i == 5'd0) begin
                    state_nx = ST_WR0;
                end else begin
                    bus.scratch_mem_read_addr = BASE_ADDR + 12'(i) - 12'd1;
                    state_nx = ST_SH_WR;
                end
            end
            ST_SH_WR: begin
                bus.scratch_mem_write_addr = BASE_ADDR + 12'(i);
                bus.scratch_mem_out        = bus.scratch_mem_in;
                bus.scratch_mem_write_en   = 1'b1;
                state_nx = ST_SH_RD;
            end
            ST_WR0: begin
                bus.scratch_mem_write_addr = BASE_ADDR;
                bus.scratch_mem_out        = sext16to32(new_val);
                bus.scratch_mem_write_en   = 1'b1;
                state_nx = ST_FIN;
            end
            ST_FIN:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Datapath registers: counter, accumulator, working value and outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            i           <= '0;
            l_tmp       <= '0;
            a           <= '0;
            mode_q      <= 1'b0;
            qua_en_q    <= '0;
            bus.done    <= 1'b0;
            bus.avg_out <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        mode_q   <= bus.mode;
                        qua_en_q <= bus.qua_en_in;
                        l_tmp    <= '0;
                        i        <= bus.mode ? 5'(DEPTH - 1) : 5'd0;
                    end
                end
                ST_ACC_ADD: begin
                    l_tmp <= bus.L_add_in;
                    i     <= i + 5'd1;
                end
                ST_AVG:  a <= bus.L_shr_in[15:0];
                ST_OFFS: a <= bus.sub_in;
                ST_CLAMP: begin
                    if (bus.sub_in[15]) a <= FLOOR;
                    i <= 5'(DEPTH - 1);
                end
`ifdef GAIN_HIST_CEIL_EN
                ST_CEIL: begin
                    if (!bus.sub_in[15] && (bus.sub_in != 16'd0)) a <= CEIL;
                end
`endif
                ST_SH_WR: i <= i - 5'd1;
                ST_WR0: begin
                    bus.avg_out <= new_val;
                    bus.done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
